// File: rtl/tsc_frame_sender.sv
// ----------------------------------------------------------------------------
// tsc_frame_sender
//
// Purpose:
//    Downstream stage of the trigger-surround cache. When the cache reports
//    done (cd) the block latches the 32-bit trigger time and pulses sbf so the
//    cache dumps its buffer. Incoming sample bytes are buffered in a small
//    FIFO and one fixed-length frame is emitted to the serial transmitter:
//       HDR, trigtm[31:24], [23:16], [15:8], [7:0], NSAMP samples [, checksum]
//    Short dumps (early sd or an idle timeout) are padded with 8'h00 so the
//    frame length never changes.
//
// Ports:
//    clk       in   1   system clock, rising edge
//    reset     in   1   synchronous, active-low reset
//    cd        in   1   cache-done level from the TSC
//    trigtm    in   32  trigger timestamp, valid while cd=1
//    sbf       out  1   send-buffer request, 1-cycle pulse
//    dat       in   8   sample byte from the TSC
//    dat_vld   in   1   sample strobe, no backpressure
//    sd        in   1   send-done pulse after the last sample byte
//    tx_data   out  8   frame byte to the transmitter
//    tx_valid  out  1   tx_data valid
//    tx_ready  in   1   transmitter accepts when tx_valid && tx_ready
//    busy      out  1   high from frame start until DONE is left
//    err       out  1   short / long / overflowed dump, cleared on frame start
//
// Configuration macro:
//    TSC_FRAME_CHKSUM_EN  when defined, a trailing XOR checksum byte (over the
//                         timestamp bytes and all sent samples) is appended.
// ----------------------------------------------------------------------------
module tsc_frame_sender #(
   parameter int         NSAMP      = 32,
   parameter logic [7:0] HDR        = 8'hA5,
   parameter int         FIFO_DEPTH = 16,
   parameter int         TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cd,
   input  logic [31:0] trigtm,
   output logic        sbf,
   input  logic [7:0]  dat,
   input  logic        dat_vld,
   input  logic        sd,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        err
);

   localparam int         AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [7:0] NSAMP_B   = 8'(NSAMP);
   localparam logic [7:0] LAST_SAMP = 8'(NSAMP - 1);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_TS,
      S_DATA,
`ifdef TSC_FRAME_CHKSUM_EN
      S_CHK,
`endif
      S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [31:0]    ts_sh_q, ts_sh_d;
   logic [1:0]     ts_idx_q, ts_idx_d;
   logic [7:0]     samp_cnt_q, samp_cnt_d;
   logic [7:0]     rx_cnt_q, rx_cnt_d;
   logic           short_q, short_d;
   logic [15:0]    to_cnt_q, to_cnt_d;
   logic           from_fifo_q, from_fifo_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]    cnt_q, cnt_d;
   logic           sbf_q, sbf_d;
   logic [7:0]     tx_data_q, tx_data_d;
   logic           tx_valid_q, tx_valid_d;
   logic           busy_q, busy_d;
   logic           err_q, err_d;
`ifdef TSC_FRAME_CHKSUM_EN
   logic [7:0]     chk_q, chk_d;
`endif

   logic [7:0]     mem [FIFO_DEPTH];
   logic           hs;
   logic           pop;
   logic           wr_en;
   logic           fifo_full;
   logic           fifo_empty;

   // Handshake and FIFO status. A pop only happens when a sample that was
   // taken from the FIFO (not a zero pad) is accepted by the transmitter, so
   // the presented byte stays at the FIFO head until it is consumed.
   always_comb begin
      hs         = tx_valid_q && tx_ready;
      pop        = (state_q == S_DATA) && hs && from_fifo_q;
      fifo_full  = (cnt_q == FULL_CNT);
      fifo_empty = (cnt_q == '0);
      wr_en      = busy_q && dat_vld && (rx_cnt_q < NSAMP_B) && (!fifo_full || pop);
   end

   // Next-state logic for the whole block: capture bookkeeping first, then
   // short-dump detection, then the frame FSM, which may override the earlier
   // assignments (frame start clears everything).
   always_comb begin
      state_d     = state_q;
      ts_sh_d     = ts_sh_q;
      ts_idx_d    = ts_idx_q;
      samp_cnt_d  = samp_cnt_q;
      rx_cnt_d    = rx_cnt_q;
      short_d     = short_q;
      to_cnt_d    = '0;
      from_fifo_d = from_fifo_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      cnt_d       = cnt_q;
      sbf_d       = 1'b0;
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;
      busy_d      = busy_q;
      err_d       = err_q;
`ifdef TSC_FRAME_CHKSUM_EN
      chk_d       = chk_q;
`endif

      // Every strobe inside a frame consumes a sample slot, even when the
      // byte is lost to overflow; strobes beyond NSAMP are an overrun.
      if (busy_q && dat_vld) begin
         if (rx_cnt_q < NSAMP_B) begin
            rx_cnt_d = rx_cnt_q + 8'd1;
            if (!wr_en) begin
               err_d = 1'b1;
            end
         end else begin
            err_d = 1'b1;
         end
      end

      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (wr_en && !pop) begin
         cnt_d = cnt_q + CNT_ONE;
      end else if (!wr_en && pop) begin
         cnt_d = cnt_q - CNT_ONE;
      end

      if (busy_q && sd && (rx_cnt_q < NSAMP_B)) begin
         short_d = 1'b1;
         err_d   = 1'b1;
      end

      // Idle watchdog: only counts while DATA is starved of samples.
      if ((state_q == S_DATA) && fifo_empty && !dat_vld && !short_q) begin
         if (to_cnt_q == TO_LAST) begin
            short_d = 1'b1;
            err_d   = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + 16'd1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (cd) begin
               ts_sh_d     = trigtm;
               ts_idx_d    = '0;
               samp_cnt_d  = '0;
               rx_cnt_d    = '0;
               short_d     = 1'b0;
               from_fifo_d = 1'b0;
               rd_ptr_d    = '0;
               wr_ptr_d    = '0;
               cnt_d       = '0;
               sbf_d       = 1'b1;
               busy_d      = 1'b1;
               err_d       = 1'b0;
               tx_data_d   = HDR;
               tx_valid_d  = 1'b1;
`ifdef TSC_FRAME_CHKSUM_EN
               chk_d       = '0;
`endif
               state_d     = S_HDR;
            end
         end

         S_HDR: begin
            if (hs) begin
               tx_data_d = ts_sh_q[31:24];
               state_d   = S_TS;
            end
         end

         // The timestamp is walked out of a shift register, MSB first.
         S_TS: begin
            if (hs) begin
`ifdef TSC_FRAME_CHKSUM_EN
               chk_d = chk_q ^ tx_data_q;
`endif
               if (ts_idx_q == 2'd3) begin
                  tx_valid_d = 1'b0;
                  state_d    = S_DATA;
               end else begin
                  ts_idx_d  = ts_idx_q + 2'd1;
                  ts_sh_d   = {ts_sh_q[23:0], 8'h00};
                  tx_data_d = ts_sh_q[23:16];
               end
            end
         end

         // One sample per handshake; a new one is loaded in the following
         // cycle, from the FIFO head if available or as a zero pad once the
         // dump has been declared short.
         S_DATA: begin
            if (hs) begin
`ifdef TSC_FRAME_CHKSUM_EN
               chk_d = chk_q ^ tx_data_q;
`endif
               samp_cnt_d  = samp_cnt_q + 8'd1;
               tx_valid_d  = 1'b0;
               from_fifo_d = 1'b0;
               if (samp_cnt_q == LAST_SAMP) begin
`ifdef TSC_FRAME_CHKSUM_EN
                  tx_data_d  = chk_q ^ tx_data_q;
                  tx_valid_d = 1'b1;
                  state_d    = S_CHK;
`else
                  state_d    = S_DONE;
`endif
               end
            end else if (!tx_valid_q) begin
               if (!fifo_empty) begin
                  tx_data_d   = mem[rd_ptr_q];
                  tx_valid_d  = 1'b1;
                  from_fifo_d = 1'b1;
               end else if (short_q) begin
                  tx_data_d   = 8'h00;
                  tx_valid_d  = 1'b1;
                  from_fifo_d = 1'b0;
               end
            end
         end

`ifdef TSC_FRAME_CHKSUM_EN
         S_CHK: begin
            if (hs) begin
               tx_valid_d = 1'b0;
               state_d    = S_DONE;
            end
         end
`endif

         // Wait for cd to drop so a held cd cannot start a second frame.
         S_DONE: begin
            tx_valid_d = 1'b0;
            if (!cd) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State register; a synchronous reset drops any frame in progress.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         ts_sh_q     <= '0;
         ts_idx_q    <= '0;
         samp_cnt_q  <= '0;
         rx_cnt_q    <= '0;
         short_q     <= 1'b0;
         to_cnt_q    <= '0;
         from_fifo_q <= 1'b0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         cnt_q       <= '0;
         sbf_q       <= 1'b0;
         tx_data_q   <= 8'h00;
         tx_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef TSC_FRAME_CHKSUM_EN
         chk_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         ts_sh_q     <= ts_sh_d;
         ts_idx_q    <= ts_idx_d;
         samp_cnt_q  <= samp_cnt_d;
         rx_cnt_q    <= rx_cnt_d;
         short_q     <= short_d;
         to_cnt_q    <= to_cnt_d;
         from_fifo_q <= from_fifo_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         cnt_q       <= cnt_d;
         sbf_q       <= sbf_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
`ifdef TSC_FRAME_CHKSUM_EN
         chk_q       <= chk_d;
`endif
      end
   end

   // Sample storage; contents need no reset because the pointers are flushed.
   always_ff @(posedge clk) begin
      if (reset && wr_en) begin
         mem[wr_ptr_q] <= dat;
      end
   end

   assign sbf      = sbf_q;
   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign busy     = busy_q;
   assign err      = err_q;

endmodule

// File: tb/tb_tsc_frame_sender.sv
// ----------------------------------------------------------------------------
// tb_tsc_frame_sender
//
// Drives whole frames into tsc_frame_sender and compares the emitted byte
// stream, err, busy and sbf behaviour against a queue-based frame model.
// ----------------------------------------------------------------------------
module tb_tsc_frame_sender;

   localparam int         NSAMP      = 20;
   localparam int         FIFO_DEPTH = 16;
   localparam int         TIMEOUT    = 30;
   localparam logic [7:0] HDR        = 8'hA5;
`ifdef TSC_FRAME_CHKSUM_EN
   localparam int         FRAME_LEN  = 6 + NSAMP;
`else
   localparam int         FRAME_LEN  = 5 + NSAMP;
`endif

   logic        clk      = 1'b0;
   logic        reset    = 1'b0;
   logic        cd       = 1'b0;
   logic [31:0] trigtm   = '0;
   logic        sbf;
   logic [7:0]  dat      = '0;
   logic        dat_vld  = 1'b0;
   logic        sd       = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        busy;
   logic        err;

   always #5 clk = ~clk;

   tsc_frame_sender #(
      .NSAMP      (NSAMP),
      .HDR        (HDR),
      .FIFO_DEPTH (FIFO_DEPTH),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .cd       (cd),
      .trigtm   (trigtm),
      .sbf      (sbf),
      .dat      (dat),
      .dat_vld  (dat_vld),
      .sd       (sd),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .busy     (busy),
      .err      (err)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] obs[$];
   logic [7:0] stored[$];
   logic [7:0] expFrame[$];
   int         sbfCount  = 0;
   bit         prevStall = 1'b0;
   logic [7:0] prevData  = '0;
   int         readyMode = 0;
   int         stallLeft = 0;
   int         rxSlots   = 0;
   bit         overrun   = 1'b0;

   // Compare one observed value with its expected value.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Advance to the next falling edge, check that a stalled byte was held,
   // choose tx_ready for the coming rising edge and log the handshake that
   // edge will perform.
   task automatic tick();
      @(negedge clk);
      if (reset === 1'b0) begin
         prevStall = 1'b0;
      end else begin
         if (prevStall) begin
            checks++;
            assert (tx_valid === 1'b1 && tx_data === prevData)
            else begin
               errors++;
               $error("[TB] FAIL hold: tx_valid=%0b tx_data=%02h, expected tx_valid=1 tx_data=%02h",
                      tx_valid, tx_data, prevData);
            end
         end
      end
      if (sbf === 1'b1) sbfCount++;
      case (readyMode)
         0: tx_ready = 1'b1;
         1: tx_ready = ~tx_ready;
         2: tx_ready = 1'($urandom_range(0, 1));
         default: begin
            if (stallLeft > 0) begin
               tx_ready = 1'b0;
               stallLeft--;
            end else begin
               tx_ready = 1'b1;
            end
         end
      endcase
      if (reset === 1'b1) begin
         if (tx_valid === 1'b1 && tx_ready === 1'b1) obs.push_back(tx_data);
         prevStall = (tx_valid === 1'b1 && tx_ready === 1'b0);
         prevData  = tx_data;
      end
   endtask

   // Frame model: header, timestamp MSB first, the bytes that reached the
   // FIFO padded with zeros to NSAMP, and optionally the XOR checksum.
   task automatic buildExpected(input logic [31:0] ts);
      logic [7:0] x;
      logic [7:0] s;
      expFrame.delete();
      expFrame.push_back(HDR);
      x = 8'h00;
      for (int i = 3; i >= 0; i--) begin
         s = ts[i*8 +: 8];
         expFrame.push_back(s);
         x ^= s;
      end
      for (int i = 0; i < NSAMP; i++) begin
         s = (i < stored.size()) ? stored[i] : 8'h00;
         expFrame.push_back(s);
         x ^= s;
      end
`ifdef TSC_FRAME_CHKSUM_EN
      expFrame.push_back(x);
`endif
   endtask

   // Present one sample byte and update the model: bytes beyond NSAMP are
   // overruns, and a byte is lost if the FIFO already holds FIFO_DEPTH
   // unconsumed samples after the handshake of the same edge.
   task automatic sendByte(input logic [7:0] b);
      int pops;
      pops = obs.size() - 5;
      if (pops < 0) pops = 0;
      if (pops > stored.size()) pops = stored.size();
      dat     = b;
      dat_vld = 1'b1;
      if (rxSlots < NSAMP) begin
         rxSlots++;
         if (stored.size() - pops < FIFO_DEPTH) stored.push_back(b);
      end else begin
         overrun = 1'b1;
      end
      tick();
      dat_vld = 1'b0;
   endtask

   // Run one complete frame and check it.
   //    base < 0 : random sample bytes, otherwise base, base+1, ...
   task automatic applyStimulus(input string name, input logic [31:0] ts, input int nbytes,
                                input int base, input int mode, input int stall, input int gapMax,
                                input bit withSd, input int holdCycles);
      int   sbf0;
      int   waitCnt;
      logic [7:0] b;
      obs.delete();
      stored.delete();
      rxSlots   = 0;
      overrun   = 1'b0;
      sbf0      = sbfCount;
      readyMode = mode;
      stallLeft = stall;
      cd        = 1'b1;
      trigtm    = ts;
      waitCnt   = 0;
      while (sbfCount == sbf0 && waitCnt < 10) begin
         tick();
         waitCnt++;
      end
      checkOutput({name, "_sbf_seen"}, sbfCount - sbf0, 1);
      checkOutput({name, "_busy_start"}, busy, 1);
      tick();
      checkOutput({name, "_sbf_pulse"}, sbf, 0);
      for (int i = 0; i < nbytes; i++) begin
         b = (base < 0) ? 8'($urandom) : 8'(base + i);
         sendByte(b);
         if (gapMax > 0) begin
            for (int g = $urandom_range(0, gapMax); g > 0; g--) tick();
         end
      end
      if (withSd) begin
         sd = 1'b1;
         tick();
         sd = 1'b0;
      end
      waitCnt = 0;
      while (obs.size() < FRAME_LEN && waitCnt < 4000) begin
         tick();
         waitCnt++;
      end
      repeat (3) tick();
      buildExpected(ts);
      checkOutput({name, "_len"}, obs.size(), FRAME_LEN);
      for (int i = 0; i < FRAME_LEN; i++) begin
         checkOutput($sformatf("%s_byte%0d", name, i),
                     (i < obs.size()) ? {24'h0, obs[i]} : 32'hFFFF, {24'h0, expFrame[i]});
      end
      checkOutput({name, "_err"}, err, (overrun || stored.size() < NSAMP) ? 1 : 0);
      checkOutput({name, "_tx_valid_done"}, tx_valid, 0);
      repeat (holdCycles) tick();
      checkOutput({name, "_busy_done"}, busy, 1);
      checkOutput({name, "_sbf_once"}, sbfCount - sbf0, 1);
      cd = 1'b0;
      waitCnt = 0;
      while (busy !== 1'b0 && waitCnt < 5) begin
         tick();
         waitCnt++;
      end
      checkOutput({name, "_busy_fall"}, busy, 0);
      checkOutput({name, "_sbf_no_rearm"}, sbfCount - sbf0, 1);
   endtask

   initial begin
      int waitCnt;

      // Reset state
      repeat (3) tick();
      checkOutput("rst_sbf", sbf, 0);
      checkOutput("rst_tx_valid", tx_valid, 0);
      checkOutput("rst_tx_data", tx_data, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_err", err, 0);
      reset = 1'b1;
      tick();

      // Strobes outside a frame are ignored without error
      dat = 8'h55;
      dat_vld = 1'b1;
      repeat (2) tick();
      dat_vld = 1'b0;
      tick();
      checkOutput("idle_dat_err", err, 0);
      checkOutput("idle_dat_busy", busy, 0);

      // Full dump, transmitter always ready
      applyStimulus("full", 32'h12345678, NSAMP, 1, 0, 0, 0, 1'b1, 0);
      // Same dump with tx_ready toggling every cycle
      applyStimulus("toggle", 32'h12345678, NSAMP, 1, 1, 0, 0, 1'b1, 0);
      // Transmitter stalled while 17 bytes arrive: 17th byte lost
      applyStimulus("overflow", 32'hCAFEF00D, 17, 8'h40, 3, 40, 0, 1'b1, 0);
      // Short dump, two bytes then sd
      applyStimulus("short", 32'h12345678, 2, 8'h0A, 0, 0, 0, 1'b1, 0);
      // One strobe more than NSAMP
      applyStimulus("overrun", 32'h0BADBEEF, NSAMP + 1, 8'h80, 0, 0, 0, 1'b1, 0);
      // No sd, sample source goes quiet: idle timeout pads the frame
      applyStimulus("timeout", 32'hDEADBEEF, 3, 8'h21, 0, 0, 0, 1'b0, 0);
      // cd held through DONE for 50 cycles
      applyStimulus("cdhold", 32'h0F1E2D3C, NSAMP, -1, 0, 0, 0, 1'b1, 50);

      // Reset during the timestamp bytes of a short (err=1) frame
      obs.delete();
      readyMode = 0;
      cd = 1'b1;
      trigtm = 32'hA1B2C3D4;
      tick();
      sd = 1'b1;
      tick();
      sd = 1'b0;
      waitCnt = 0;
      while (obs.size() < 3 && waitCnt < 50) begin
         tick();
         waitCnt++;
      end
      checkOutput("midrst_pre_err", err, 1);
      reset = 1'b0;
      cd = 1'b0;
      tick();
      reset = 1'b1;
      checkOutput("midrst_tx_valid", tx_valid, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_err", err, 0);
      checkOutput("midrst_sbf", sbf, 0);
      tick();
      applyStimulus("after_rst", 32'h13579BDF, NSAMP, -1, 0, 0, 0, 1'b1, 0);

      // Randomised frames
      for (int f = 0; f < 6; f++) begin
         applyStimulus($sformatf("rand%0d", f), $urandom, $urandom_range(1, NSAMP + 1), -1,
                       $urandom_range(0, 2), 0, $urandom_range(0, 2), 1'b1, $urandom_range(0, 5));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
